// File: rtl/switch_sched.sv
// Command sequencer for the PE<->memory-group switch network: fixes sw_ctrl per command,
// gates source beats and tracks them through the fixed pipeline. Option: SWITCH_SCHED_PERF_EN.
module switch_sched #(
  parameter int unsigned NUM_MG  = 8,
  parameter int unsigned LATENCY = 8,
  parameter int unsigned BEAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_mode,
  input  logic [BEAT_W-1:0] cmd_beats,
  input  logic              src_valid,
  output logic              src_ready,
  output logic              sw_ctrl,
  output logic              sw_out_valid,
  output logic              busy,
  output logic              done
`ifdef SWITCH_SCHED_PERF_EN
  ,
  output logic [31:0]       perf_busy_cyc,
  output logic [31:0]       perf_bubble_cyc
`endif
);

  // Input register plus NUM_MG-1 switch stages; the tracker depth must match the network.
  if (LATENCY != NUM_MG || LATENCY < 2) begin : g_latency_check
    $error("switch_sched: LATENCY must equal NUM_MG and be at least 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  state_e              state_q, state_d;
  logic                rdy_en_q, rdy_en_d;
  logic [BEAT_W-1:0]   remaining_q, remaining_d;
  logic [LATENCY-1:0]  tracker_q, tracker_d;
  logic                sw_ctrl_q, sw_ctrl_d;
  logic                done_q, done_d;
  logic                cmd_fire;
  logic                src_fire;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign src_fire  = src_valid & src_ready;
  assign tracker_d = {tracker_q[LATENCY-2:0], src_fire};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // DRAIN exits when the tracker is about to empty, so done lands with the first IDLE cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_fire && cmd_beats != '0) state_d = RUN;
      RUN:     if (src_fire && remaining_q == BEAT_W'(1)) state_d = DRAIN;
      DRAIN:   if (tracker_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready    = (state_q == IDLE) & rdy_en_q;
    src_ready    = (state_q == RUN);
    busy         = (state_q != IDLE);
    sw_ctrl      = sw_ctrl_q;
    sw_out_valid = tracker_q[LATENCY-1];
    done         = done_q;
  end

  always_comb begin
    rdy_en_d    = 1'b1;
    remaining_d = remaining_q;
    sw_ctrl_d   = sw_ctrl_q;
    if (cmd_fire) begin
      sw_ctrl_d   = cmd_mode;
      remaining_d = cmd_beats;
    end else if (src_fire && remaining_q != '0) begin
      remaining_d = remaining_q - BEAT_W'(1);
    end
    done_d = (cmd_fire && cmd_beats == '0) || (state_q == DRAIN && state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_en_q    <= 1'b0;
      remaining_q <= '0;
      tracker_q   <= '0;
      sw_ctrl_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      rdy_en_q    <= rdy_en_d;
      remaining_q <= remaining_d;
      tracker_q   <= tracker_d;
      sw_ctrl_q   <= sw_ctrl_d;
      done_q      <= done_d;
    end
  end

`ifdef SWITCH_SCHED_PERF_EN
  logic [31:0] busy_cyc_q, busy_cyc_d;
  logic [31:0] bubble_cyc_q, bubble_cyc_d;

  always_comb begin
    busy_cyc_d   = busy_cyc_q;
    bubble_cyc_d = bubble_cyc_q;
    if (state_q != IDLE && busy_cyc_q != '1) busy_cyc_d = busy_cyc_q + 32'd1;
    if (state_q == RUN && !src_valid && bubble_cyc_q != '1) bubble_cyc_d = bubble_cyc_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cyc_q   <= '0;
      bubble_cyc_q <= '0;
    end else begin
      busy_cyc_q   <= busy_cyc_d;
      bubble_cyc_q <= bubble_cyc_d;
    end
  end

  assign perf_busy_cyc   = busy_cyc_q;
  assign perf_bubble_cyc = bubble_cyc_q;
`endif

endmodule

// File: tb/tb_switch_sched.sv
// Scoreboard bench for switch_sched: the driver predicts each cycle's status and future
// output/done events from command-level rules; a negedge monitor pops and compares.
module tb_switch_sched;
  localparam int unsigned LAT = 8;
  localparam int unsigned BW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_mode = 1'b0;
  logic [BW-1:0] cmd_beats = '0;
  logic          src_valid = 1'b0;
  logic          cmd_ready, src_ready, sw_ctrl, sw_out_valid, busy, done;
`ifdef SWITCH_SCHED_PERF_EN
  logic [31:0]   perf_busy_cyc, perf_bubble_cyc;
`endif

  always #5 clk = ~clk;

  switch_sched #(.NUM_MG(8), .LATENCY(LAT), .BEAT_W(BW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_mode     (cmd_mode),
    .cmd_beats    (cmd_beats),
    .src_valid    (src_valid),
    .src_ready    (src_ready),
    .sw_ctrl      (sw_ctrl),
    .sw_out_valid (sw_out_valid),
    .busy         (busy),
    .done         (done)
`ifdef SWITCH_SCHED_PERF_EN
    ,
    .perf_busy_cyc   (perf_busy_cyc),
    .perf_bubble_cyc (perf_bubble_cyc)
`endif
  );

  typedef struct {
    int          cyc;
    bit          cmd_ready;
    bit          src_ready;
    bit          busy;
    bit          sw_ctrl;
    int unsigned pbusy;
    int unsigned pbub;
  } stat_t;

  typedef struct {
    int cyc;
    bit mode;
  } ev_t;

  stat_t stat_q[$];
  ev_t   out_q[$];
  int    done_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Command-level reference: beats still owed, cycle the pipe is empty again, current mode.
  int          m_left     = 0;
  int          m_idle_at  = 0;
  int          m_rdy_from = 1 << 30;
  bit          m_mode     = 1'b0;
  int unsigned m_pbusy    = 0;
  int unsigned m_pbub     = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit cv, input bit md, input int b, input bit sv);
    stat_t s;
    bit    was_rst;
    bit    e_rdy, e_src, e_busy;
    @(posedge clk);
    cyc++;
    #1;
    was_rst   = !rst;
    rst       = r;
    cmd_valid = cv;
    cmd_mode  = md;
    cmd_beats = BW'(b);
    src_valid = sv;
    if (!r) begin
      out_q.delete();
      done_q.delete();
      m_left     = 0;
      m_idle_at  = 0;
      m_mode     = 1'b0;
      m_rdy_from = 1 << 30;
      m_pbusy    = 0;
      m_pbub     = 0;
    end else if (was_rst) begin
      m_rdy_from = cyc + 1;
    end
    e_rdy  = r && cyc >= m_rdy_from && m_left == 0 && cyc >= m_idle_at;
    e_src  = r && m_left > 0;
    e_busy = r && (m_left > 0 || cyc < m_idle_at);
    s = '{cyc, e_rdy, e_src, e_busy, m_mode, m_pbusy, m_pbub};
    stat_q.push_back(s);
    if (r) begin
      if (e_busy) m_pbusy++;
      if (e_src && !sv) m_pbub++;
      if (cv && e_rdy) begin
        m_mode = md;
        if (b == 0) done_q.push_back(cyc + 1);
        else m_left = b;
      end else if (e_src && sv) begin
        out_q.push_back('{cyc + LAT, m_mode});
        m_left--;
        if (m_left == 0) begin
          m_idle_at = cyc + LAT + 1;
          done_q.push_back(cyc + LAT + 1);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic run_src(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, 1'b1);
  endtask

  initial begin : monitor
    stat_t s;
    ev_t   e;
    bit    exp_v, exp_d;
    forever begin
      @(negedge clk);
      if (stat_q.size() == 0) continue;
      s = stat_q.pop_front();
      check("cmd_ready", cmd_ready, s.cmd_ready);
      check("src_ready", src_ready, s.src_ready);
      check("busy", busy, s.busy);
      check("sw_ctrl", sw_ctrl, s.sw_ctrl);
`ifdef SWITCH_SCHED_PERF_EN
      check("perf_busy_cyc", perf_busy_cyc, s.pbusy);
      check("perf_bubble_cyc", perf_bubble_cyc, s.pbub);
`endif
      exp_v = out_q.size() > 0 && out_q[0].cyc == s.cyc;
      check("sw_out_valid", sw_out_valid, exp_v);
      if (exp_v) begin
        e = out_q.pop_front();
        check("out_mode", sw_ctrl, e.mode);
      end
      exp_d = done_q.size() > 0 && done_q[0] == s.cyc;
      check("done", done, exp_d);
      if (exp_d) void'(done_q.pop_front());
    end
  end

  initial begin : driver
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(2);

    // mode 1, 4 beats, source always ready
    step(1'b1, 1'b1, 1'b1, 4, 1'b1);
    run_src(14);

    // 4 beats with source bubbles 1,0,1,0,1,1
    step(1'b1, 1'b1, 1'b0, 4, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle(12);

    // zero-beat command
    step(1'b1, 1'b1, 1'b1, 0, 1'b0);
    idle(3);

    // back-to-back: B held valid while A is in flight
    step(1'b1, 1'b1, 1'b0, 3, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b1, 2, 1'b1);
    idle(14);

    // reset during DRAIN with beats in flight, then a fresh command
    step(1'b1, 1'b1, 1'b1, 6, 1'b1);
    run_src(6);
    idle(2);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 0, 1'b0);
    idle(12);
    step(1'b1, 1'b1, 1'b1, 2, 1'b1);
    run_src(2);
    idle(12);

    // 2 beats with one bubble
    step(1'b1, 1'b1, 1'b0, 2, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 0, 1'b1);
    idle(12);

    for (int i = 0; i < 800; i++) begin
      step(($urandom % 250) != 0, ($urandom % 4) == 0, 1'($urandom % 2),
           int'($urandom % 7), ($urandom % 4) != 0);
    end
    idle(14);

    @(negedge clk);
    #1;
    check("pending_out", out_q.size(), 0);
    check("pending_done", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
